// File: rtl/i_fetch_if.sv
// ---------------------------------------------------------------------------
// i_fetch_if
// Bundle between the instruction-fetch stage and the rest of the pipeline.
// The pipeline side (master) drives the run/hold/redirect controls. The
// fetch stage (slave) returns the registered instruction and the sticky
// HALT flag.
// Signal names keep the stage's own i_/o_ naming, seen from the fetch stage.
// ---------------------------------------------------------------------------
interface i_fetch_if #(
    parameter int NBITS = 32
);
    logic             i_enable;
    logic             i_halt;
    logic             i_stall;
    logic [NBITS-1:0] i_jump_address;
    logic             i_jump_select;
    logic [NBITS-1:0] o_instruction;
    logic             o_halt_signal;

    // Pipeline side: drives controls and observes the fetched word.
    modport master (
        output i_enable,
        output i_halt,
        output i_stall,
        output i_jump_address,
        output i_jump_select,
        input  o_instruction,
        input  o_halt_signal
    );

    // Fetch stage side.
    modport slave (
        input  i_enable,
        input  i_halt,
        input  i_stall,
        input  i_jump_address,
        input  i_jump_select,
        output o_instruction,
        output o_halt_signal
    );
endinterface

// File: rtl/i_fetch.sv
// ---------------------------------------------------------------------------
// i_fetch
// Instruction-fetch stage of a 5-stage MIPS pipeline.
//  - Word-addressed PC, wrapping modulo MEM_DEPTH.
//  - Internal read-only instruction ROM with a registered read. The
//    o_instruction register is the ROM output register.
//  - The stage honours enable, external halt, stall and jump redirects.
//    A jump keeps one delay slot: the word at the current PC is still issued.
//  - When the HALT encoding is fetched, a sticky flag is set. The stage
//    then freezes until reset.
// ROM image: built-in, ROM[i] = i, and the last word is HALT_WORD.
// ---------------------------------------------------------------------------
module i_fetch #(
    parameter int               NBITS     = 32,
    parameter int               MEM_DEPTH = 256,
    parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter string            INIT_FILE = "program.mem"
) (
    input  logic        i_clk,
    input  logic        i_reset,
    i_fetch_if.slave    bus
);

    localparam int AW = $clog2(MEM_DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [AW-1:0]    pc_q;
    logic [AW-1:0]    pc_d;
    logic [NBITS-1:0] instr_q;
    logic [NBITS-1:0] instr_d;
    logic             halt_q;
    logic             halt_d;

    logic [NBITS-1:0] rom_data_s;
    logic             frozen_s;
    logic             fetch_s;
    logic             rom_is_halt_s;

    // The ROM is indexed by only the low AW bits of a jump target.
    // The upper bits are folded here so that they are not reported as
    // left-over bits.
    logic             unused_jump_hi_s;
    assign unused_jump_hi_s = ^bus.i_jump_address[NBITS-1:AW];

    // -----------------------------------------------------------------------
    // Instruction ROM
    // -----------------------------------------------------------------------
    // Built-in image: every word holds its own index, and the last word holds HALT.
    function automatic logic [NBITS-1:0] rom_default(input logic [AW-1:0] addr);
        logic [NBITS-1:0] word;
        if (addr == AW'(MEM_DEPTH - 1)) begin
            word = HALT_WORD;
        end else begin
            word = NBITS'(addr);
        end
        return word;
    endfunction

    // ROM lookup at the current PC.
    always_comb begin
        rom_data_s = rom_default(pc_q);
    end

    // -----------------------------------------------------------------------
    // Control decode
    // -----------------------------------------------------------------------
    // Classify this cycle as frozen or fetching. Stall holds the stage
    // without freezing it. Stall takes priority over jump, so the
    // requester must keep i_jump_select asserted until the stall clears.
    always_comb begin
        frozen_s      = (!bus.i_enable) | bus.i_halt | halt_q;
        fetch_s       = 1'b0;
        rom_is_halt_s = (rom_data_s == HALT_WORD);
        if (frozen_s) begin
            fetch_s = 1'b0;
        end else if (bus.i_stall) begin
            fetch_s = 1'b0;
        end else begin
            fetch_s = 1'b1;
        end
    end

    // Next-state logic for the PC, the output register and the sticky halt flag.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        halt_d  = halt_q;
        if (fetch_s) begin
            instr_d = rom_data_s;
            halt_d  = halt_q | rom_is_halt_s;
            if (bus.i_jump_select) begin
                pc_d = bus.i_jump_address[AW-1:0];
            end else begin
                pc_d = pc_q + AW'(1);
            end
        end else begin
            pc_d    = pc_q;
            instr_d = instr_q;
            halt_d  = halt_q;
        end
    end

    // State register with synchronous active-high reset. Reset restarts
    // fetch at PC 0 with a NOP on the output.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q    <= '0;
            instr_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            halt_q  <= halt_d;
        end
    end

    assign bus.o_instruction = instr_q;
    assign bus.o_halt_signal = halt_q;

endmodule

// File: tb/tb_i_fetch.sv
// ---------------------------------------------------------------------------
// tb_i_fetch
// Directed testbench for the instruction-fetch stage, using the default
// ROM image (ROM[i] = i, ROM[255] = HALT).
// Inputs change 1 ns after each rising edge. The registered outputs are
// sampled at that same point.
// ---------------------------------------------------------------------------
module tb_i_fetch;

    localparam int               NBITS = 32;
    localparam logic [NBITS-1:0] HALTW = 32'hFFFF_FFFF;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    i_fetch_if #(.NBITS(NBITS)) bus ();

    i_fetch #(
        .NBITS    (NBITS),
        .MEM_DEPTH(256),
        .HALT_WORD(HALTW)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus.slave)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value with its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare both outputs after one edge.
    task automatic step_check(input string tag, input logic [31:0] exp_instr, input logic exp_halt);
        step();
        check({tag, "_instr"}, bus.o_instruction, exp_instr);
        check({tag, "_halt"}, {31'd0, bus.o_halt_signal}, {31'd0, exp_halt});
    endtask

    // Directed test sequence.
    initial begin
        checks = 0;
        errors = 0;
        rst                = 1'b1;
        bus.i_enable       = 1'b0;
        bus.i_halt         = 1'b0;
        bus.i_stall        = 1'b0;
        bus.i_jump_address = 32'd0;
        bus.i_jump_select  = 1'b0;

        // Reset for 2 cycles: outputs show NOP and no halt.
        step_check("reset0", 32'd0, 1'b0);
        step_check("reset1", 32'd0, 1'b0);

        // Sequential fetch: edges 1 to 3 give 0, 1, 2 (PC ends at 3).
        rst          = 1'b0;
        bus.i_enable = 1'b1;
        step_check("seq0", 32'd0, 1'b0);
        step_check("seq1", 32'd1, 1'b0);
        step_check("seq2", 32'd2, 1'b0);

        // Stall for 3 cycles holds 2. After release, fetch resumes with 3, then 4.
        bus.i_stall = 1'b1;
        step_check("stall0", 32'd2, 1'b0);
        step_check("stall1", 32'd2, 1'b0);
        step_check("stall2", 32'd2, 1'b0);
        bus.i_stall = 1'b0;
        step_check("stall_rel", 32'd3, 1'b0);
        step_check("seq4", 32'd4, 1'b0);

        // Jump to 100 while PC = 5: the delay slot issues 5, then 100 and 101.
        bus.i_jump_select  = 1'b1;
        bus.i_jump_address = 32'd100;
        step_check("jmp_slot", 32'd5, 1'b0);
        bus.i_jump_select  = 1'b0;
        step_check("jmp_tgt", 32'd100, 1'b0);
        step_check("jmp_tgt1", 32'd101, 1'b0);

        // Enable low holds the stage. Re-enabling continues with 102.
        bus.i_enable = 1'b0;
        step_check("dis0", 32'd101, 1'b0);
        step_check("dis1", 32'd101, 1'b0);
        bus.i_enable = 1'b1;
        step_check("en_res", 32'd102, 1'b0);

        // External halt holds the stage. Releasing it continues with 103.
        bus.i_halt = 1'b1;
        step_check("xhalt0", 32'd102, 1'b0);
        step_check("xhalt1", 32'd102, 1'b0);
        bus.i_halt = 1'b0;
        step_check("xhalt_res", 32'd103, 1'b0);

        // Stall beats jump: 103 is held while stalled.
        // Once released, the delay slot issues 104, then the target 200.
        bus.i_stall        = 1'b1;
        bus.i_jump_select  = 1'b1;
        bus.i_jump_address = 32'd200;
        step_check("stjmp_hold", 32'd103, 1'b0);
        bus.i_stall        = 1'b0;
        step_check("stjmp_slot", 32'd104, 1'b0);
        bus.i_jump_select  = 1'b0;
        step_check("stjmp_tgt", 32'd200, 1'b0);

        // Upper jump bits are ignored: target 0x132 lands on word 0x32.
        bus.i_jump_select  = 1'b1;
        bus.i_jump_address = 32'h0000_0132;
        step_check("hi_slot", 32'd201, 1'b0);
        bus.i_jump_select  = 1'b0;
        step_check("hi_tgt", 32'h0000_0032, 1'b0);

        // Jump to 255: the slot issues 51. Then HALT appears with the flag
        // raised on the same edge.
        bus.i_jump_select  = 1'b1;
        bus.i_jump_address = 32'd255;
        step_check("h_slot", 32'd51, 1'b0);
        bus.i_jump_select  = 1'b0;
        step_check("h_fetch", HALTW, 1'b1);

        // Frozen for 5 cycles while jump and stall toggle.
        bus.i_jump_address = 32'd10;
        bus.i_jump_select  = 1'b1;
        step_check("frz0", HALTW, 1'b1);
        bus.i_stall        = 1'b1;
        step_check("frz1", HALTW, 1'b1);
        bus.i_jump_select  = 1'b0;
        step_check("frz2", HALTW, 1'b1);
        bus.i_stall        = 1'b0;
        step_check("frz3", HALTW, 1'b1);
        bus.i_jump_select  = 1'b1;
        step_check("frz4", HALTW, 1'b1);
        bus.i_jump_select  = 1'b0;

        // Reset while halted clears both outputs. The sequence then restarts at ROM[0].
        rst = 1'b1;
        step_check("hrst", 32'd0, 1'b0);
        rst = 1'b0;
        step_check("rst_seq0", 32'd0, 1'b0);
        step_check("rst_seq1", 32'd1, 1'b0);
        step_check("rst_seq2", 32'd2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
